magic_square_gen: RTL

- Sequential producer for the 3x3 magic-square checkers (isMagic / isValid / inRange).
- On start, emits all 8 symmetries of the Lo Shu square (4 rotations x optional mirror), each shifted by a latched offset.
- Output is presented as a parallel grid with a valid/ready handshake, with its magic constant alongside.
- Feeds the checkers directly: num1..num9 are row-major, num1 top-left, num9 bottom-right.

---
 rtl/magic_square_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/magic_square_gen.sv
// Sequential producer of the eight Lo Shu symmetries (4 rotations x optional mirror),
// each shifted by a latched offset, presented as a 3x3 grid over a valid/ready handshake.
module magic_square_gen #(
   parameter int MAX_OFFSET = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] offset,
   input  logic       ready,
   output logic       valid,
   output logic [3:0] num1,
   output logic [3:0] num2,
   output logic [3:0] num3,
   output logic [3:0] num4,
   output logic [3:0] num5,
   output logic [3:0] num6,
   output logic [3:0] num7,
   output logic [3:0] num8,
   output logic [3:0] num9,
   output logic [7:0] magic_constant,
   output logic [2:0] variant,
   output logic       last,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [1:0] {
      IDLE,
      PRESENT,
      FINISH
   } state_t;

   localparam logic [3:0] MAX_OFF = 4'(MAX_OFFSET);

   // Cell k of the returned grid is row-major position k (0 = top-left).
   function automatic logic [8:0][3:0] build_square(input logic [2:0] v, input logic [3:0] off);
      logic [3:0]       g   [9];
      logic [3:0]       t   [9];
      logic [8:0][3:0]  res;
      g = '{4'd2, 4'd7, 4'd6, 4'd9, 4'd5, 4'd1, 4'd4, 4'd3, 4'd8};
      t = g;
      if (v[2]) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               t[r*3+c] = g[r*3+2-c];
      end
      g = t;
      for (int k = 0; k < 3; k++) begin
         if (k < int'(v[1:0])) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  t[r*3+c] = g[(2-c)*3+r];
            g = t;
         end
      end
      for (int i = 0; i < 9; i++) res[i] = g[i] + off;
      return res;
   endfunction

   state_t          state_q,   state_d;
   logic [3:0]      off_q,     off_d;
   logic [2:0]      variant_q, variant_d;
   logic            valid_q,   valid_d;
   logic            last_q,    last_d;
   logic            busy_q,    busy_d;
   logic            done_q,    done_d;
   logic            error_q,   error_d;
   logic [8:0][3:0] cells_q,   cells_d;
   logic [7:0]      magic_q,   magic_d;
   logic            load;

   always_comb begin
      // NOTE: every signal gets a hold/default value up front so no path leaves one unassigned, which would infer a latch.
      state_d   = state_q;
      off_d     = off_q;
      variant_d = variant_q;
      valid_d   = valid_q;
      last_d    = last_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = 1'b0;
      cells_d   = cells_q;
      magic_d   = magic_q;
      load      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (offset > MAX_OFF) begin
                  error_d = 1'b1;
               end else begin
                  off_d     = offset;
                  state_d   = PRESENT;
                  valid_d   = 1'b1;
                  busy_d    = 1'b1;
                  variant_d = 3'd0;
                  last_d    = 1'b0;
                  load      = 1'b1;
               end
            end
         end
         PRESENT: begin
            if (valid_q && ready) begin
               if (variant_q == 3'd7) begin
                  state_d = FINISH;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  variant_d = variant_q + 3'd1;
                  last_d    = (variant_q == 3'd6);
                  load      = 1'b1;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      // Grid and constant follow the variant about to be registered, so they change only on a load.
      if (load) begin
         cells_d = build_square(variant_d, off_d);
         magic_d = 8'd15 + 8'd3 * {4'd0, off_d};
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         off_q     <= 4'd0;
         variant_q <= 3'd0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         cells_q   <= '0;
         magic_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         off_q     <= off_d;
         variant_q <= variant_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         cells_q   <= cells_d;
         magic_q   <= magic_d;
      end
   end

   assign valid          = valid_q;
   assign variant        = variant_q;
   assign last           = last_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign magic_constant = magic_q;
   assign num1           = cells_q[0];
   assign num2           = cells_q[1];
   assign num3           = cells_q[2];
   assign num4           = cells_q[3];
   assign num5           = cells_q[4];
   assign num6           = cells_q[5];
   assign num7           = cells_q[6];
   assign num8           = cells_q[7];
   assign num9           = cells_q[8];

endmodule
